// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter_pkg
// Description : Shared constants and types for the data-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_port_arbiter_pkg;

    // Store-size funct3 encodings (RV32 S-type)
    localparam logic [2:0] FNC_SB = 3'b000;
    localparam logic [2:0] FNC_SH = 3'b001;
    localparam logic [2:0] FNC_SW = 3'b010;

    localparam int PORT_CPU  = 0;
    localparam int PORT_UART = 1;

    localparam int TAG_OWNER_W = 1;

    typedef struct packed {
        logic                   valid;
        logic                   load;
        logic [TAG_OWNER_W-1:0] owner;
    } rsp_tag_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } st_size_e;

    // Unknown funct3 values fall back to a full-word store.
    function automatic st_size_e decode_size(input logic [2:0] f3);
        case (f3)
            FNC_SB:  return SZ_BYTE;
            FNC_SH:  return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter_store_fmt.sv
`default_nettype none
// ============================================================================
// Module      : dmem_store_fmt
// Description : Store formatting: byte enables, lane replication, misalignment.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_store_fmt
    import dmem_port_arbiter_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    output logic        misaligned
);

    always_comb begin
        mem_we     = 4'b0000;
        mem_wdata  = wdata;
        misaligned = 1'b0;
        case (decode_size(funct3))
            SZ_BYTE: begin
                mem_we    = 4'b0001 << addr_lo;
                mem_wdata = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                mem_we     = addr_lo[1] ? 4'b1100 : 4'b0011;
                mem_wdata  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            default: begin
                mem_we     = 4'b1111;
                misaligned = |addr_lo;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Two-port arbiter in front of a single-port data BRAM.
//               Optional DMEM_ARB_CPU_PRIO_EN: fixed CPU priority instead of
//               round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int MEM_AW = 12,
    parameter int NREQ   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ-1:0]    we_i,
    input  logic [NREQ*3-1:0]  funct3_i,
    input  logic [NREQ*32-1:0] addr_i,
    input  logic [NREQ*32-1:0] wdata_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic [NREQ-1:0]    rvalid_o,
    output logic [31:0]        rdata_o,
    output logic [NREQ-1:0]    err_o,
    output logic               mem_en,
    output logic [3:0]         mem_we,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    logic        w_any;
    logic        w_sel;
    logic        w_we;
    logic [2:0]  w_f3;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_fmt_we;
    logic [31:0] w_fmt_wdata;
    logic        w_misal;
    logic        w_unused_addr;

    rsp_tag_t         r_tag;
    logic [NREQ-1:0]  r_err;
`ifndef DMEM_ARB_CPU_PRIO_EN
    logic             r_last_gnt;
`endif

    // Grants are suppressed while reset is held so the BRAM sees no access.
    always_comb begin
        w_any = 1'b0;
        w_sel = 1'(PORT_CPU);
        if (rst_n) begin
            if (req_i[PORT_CPU] && req_i[PORT_UART]) begin
                w_any = 1'b1;
`ifdef DMEM_ARB_CPU_PRIO_EN
                w_sel = 1'(PORT_CPU);
`else
                w_sel = ~r_last_gnt;
`endif
            end else if (req_i[PORT_CPU]) begin
                w_any = 1'b1;
                w_sel = 1'(PORT_CPU);
            end else if (req_i[PORT_UART]) begin
                w_any = 1'b1;
                w_sel = 1'(PORT_UART);
            end
        end
    end

    assign gnt_o   = w_any ? (2'b01 << w_sel) : 2'b00;
    assign w_we    = w_sel ? we_i[PORT_UART] : we_i[PORT_CPU];
    assign w_f3    = w_sel ? funct3_i[3*PORT_UART +: 3] : funct3_i[3*PORT_CPU +: 3];
    assign w_addr  = w_sel ? addr_i[32*PORT_UART +: 32] : addr_i[32*PORT_CPU +: 32];
    assign w_wdata = w_sel ? wdata_i[32*PORT_UART +: 32] : wdata_i[32*PORT_CPU +: 32];

    assign w_unused_addr = ^w_addr[31:MEM_AW+2];

    dmem_store_fmt u_store_fmt (
        .funct3     (w_f3),
        .addr_lo    (w_addr[1:0]),
        .wdata      (w_wdata),
        .mem_we     (w_fmt_we),
        .mem_wdata  (w_fmt_wdata),
        .misaligned (w_misal)
    );

    // Misaligned stores still occupy the slot but write nothing.
    assign mem_en    = w_any;
    assign mem_we    = (w_any && w_we && !w_misal) ? w_fmt_we : 4'b0000;
    assign mem_addr  = w_addr[MEM_AW+1:2];
    assign mem_wdata = w_fmt_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= '0;
            r_err <= '0;
        end else begin
            r_tag <= '{valid: w_any, load: ~w_we, owner: w_sel};
            r_err <= (w_any && w_we && w_misal) ? gnt_o : '0;
        end
    end

`ifndef DMEM_ARB_CPU_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
        end else if (w_any) begin
            r_last_gnt <= w_sel;
        end
    end
`endif

    always_comb begin
        rvalid_o = '0;
        if (r_tag.valid && r_tag.load) begin
            rvalid_o[r_tag.owner] = 1'b1;
        end
    end

    assign rdata_o = mem_rdata;
    assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Self-checking bench: BRAM model, reference model, directed tests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_i, we_i;
    logic [5:0]  funct3_i;
    logic [63:0] addr_i, wdata_i;
    logic [1:0]  gnt_o, rvalid_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;

    dmem_port_arbiter #(.MEM_AW(12), .NREQ(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // BRAM model with one-cycle read latency; preloaded on the first edge.
    logic [31:0] bram [0:4095];
    bit bram_init = 1'b0;
    always @(posedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < 4096; i++) bram[i] <= 32'h0;
            bram[4] <= 32'hDEADBEEF;
            bram[8] <= 32'h12345678;
            bram_init <= 1'b1;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= bram[mem_addr];
        end
    end

    // Reference model: memory image, arbitration pointer, one pending response.
    logic [31:0] ref_mem [0:4095];
    bit          ref_init = 1'b0;
    int          m_last;
    bit          p_valid, p_load;
    int          p_owner;
    logic [31:0] p_data;
    logic [1:0]  p_err;

    always @(negedge clk) begin : cmp
        int k, n;
        logic [31:0] a, d, ew, ed;
        logic [1:0]  eg, erv;
        logic [11:0] wa;
        if (!ref_init) begin
            for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
            ref_mem[4] = 32'hDEADBEEF;
            ref_mem[8] = 32'h12345678;
            ref_init = 1'b1;
        end
        if (!rst_n) begin
            chk("rst_gnt", gnt_o, 0);
            chk("rst_rvalid", rvalid_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            m_last  = 1;
            p_valid = 1'b0;
            p_err   = 2'b00;
        end else begin
            erv = (p_valid && p_load) ? 2'(1 << p_owner) : 2'b00;
            chk("m_rvalid", rvalid_o, erv);
            if (erv != 2'b00) chk("m_rdata", rdata_o, p_data);
            chk("m_err", err_o, p_err);

            k = -1;
            if (req_i == 2'b11) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                k = 0;
`else
                k = (m_last == 0) ? 1 : 0;
`endif
            end else if (req_i[0]) k = 0;
            else if (req_i[1]) k = 1;
            eg = (k < 0) ? 2'b00 : 2'(1 << k);
            chk("m_gnt", gnt_o, eg);

            p_valid = 1'b0;
            p_err   = 2'b00;
            if (k >= 0) begin
                a  = addr_i[32*k +: 32];
                d  = wdata_i[32*k +: 32];
                wa = 12'((a >> 2) % 4096);
                chk("m_mem_en", mem_en, 1);
                chk("m_mem_addr", mem_addr, wa);
                if (we_i[k]) begin
                    case (funct3_i[3*k +: 3])
                        3'b000:  n = 1;
                        3'b001:  n = 2;
                        default: n = 4;
                    endcase
                    if ((a % n) != 0) begin
                        chk("m_we_misal", mem_we, 0);
                        p_err = eg;
                    end else begin
                        ew = 0;
                        for (int i = 0; i < n; i++) ew[(a % 4) + i] = 1'b1;
                        for (int i = 0; i < 4; i++) ed[8*i +: 8] = d[8*(i % n) +: 8];
                        chk("m_we", mem_we, ew);
                        chk("m_wdata", mem_wdata, ed);
                        for (int i = 0; i < n; i++)
                            ref_mem[wa][8*((a % 4) + i) +: 8] = d[8*i +: 8];
                    end
                end else begin
                    chk("m_we_load", mem_we, 0);
                    p_data = ref_mem[wa];
                end
                p_valid = 1'b1;
                p_load  = !we_i[k];
                p_owner = k;
                m_last  = k;
            end else begin
                chk("m_idle_en", mem_en, 0);
                chk("m_idle_we", mem_we, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_i = 0; we_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    endtask

    task automatic drv(input logic [1:0] rq, input logic [1:0] w, input logic [5:0] f,
                       input logic [63:0] a, input logic [63:0] d);
        req_i = rq; we_i = w; funct3_i = f; addr_i = a; wdata_i = d;
    endtask

    logic [1:0] seq [4];

    initial begin
`ifdef DMEM_ARB_CPU_PRIO_EN
        seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        chk("reset_gnt", gnt_o, 0);
        chk("reset_rvalid", rvalid_o, 0);
        chk("reset_mem_en", mem_en, 0);
        step(); step();
        rst_n = 1'b1;

        // Contention: both ports load every cycle
        drv(2'b11, 2'b00, 6'h0, {32'h20, 32'h10}, 64'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("cont_gnt", gnt_o, seq[c]);
            if (c > 0) begin
                chk("cont_rvalid", rvalid_o, seq[c-1]);
                chk("cont_rdata", rdata_o, (seq[c-1] == 2'b01) ? 32'hDEADBEEF : 32'h12345678);
            end
            step();
        end
        idle();
        @(negedge clk);
        chk("cont_rvalid_last", rvalid_o, seq[3]);
        chk("cont_rdata_last", rdata_o, (seq[3] == 2'b01) ? 32'hDEADBEEF : 32'h12345678);

        // Port 0 load of word 4
        step();
        drv(2'b01, 2'b00, 6'h0, {32'h0, 32'h10}, 64'h0);
        @(negedge clk);
        chk("ld0_gnt", gnt_o, 2'b01);
        chk("ld0_addr", mem_addr, 12'd4);
        chk("ld0_we", mem_we, 4'b0000);
        step(); idle();
        @(negedge clk);
        chk("ld0_rvalid", rvalid_o, 2'b01);
        chk("ld0_rdata", rdata_o, 32'hDEADBEEF);

        // Port 1 SB at 0x23
        step();
        drv(2'b10, 2'b10, {3'b000, 3'b000}, {32'h23, 32'h0}, {32'hA5, 32'h0});
        @(negedge clk);
        chk("sb_gnt", gnt_o, 2'b10);
        chk("sb_we", mem_we, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        step(); idle();
        @(negedge clk);
        chk("sb_rvalid", rvalid_o, 2'b00);
        chk("sb_err", err_o, 2'b00);

        // Port 0 SH aligned then misaligned, followed by pipelined loads
        step();
        drv(2'b01, 2'b01, {3'b000, 3'b001}, {32'h0, 32'h06}, {32'h0, 32'h1234CAFE});
        @(negedge clk);
        chk("sh_we", mem_we, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hCAFECAFE);
        step();
        drv(2'b01, 2'b01, {3'b000, 3'b001}, {32'h0, 32'h07}, {32'h0, 32'h5555AAAA});
        @(negedge clk);
        chk("shm_we", mem_we, 4'b0000);
        chk("shm_en", mem_en, 1'b1);
        step();
        drv(2'b10, 2'b00, 6'h0, {32'h20, 32'h0}, 64'h0);
        @(negedge clk);
        chk("shm_err", err_o, 2'b01);
        chk("ld1_gnt", gnt_o, 2'b10);
        step();
        drv(2'b01, 2'b00, 6'h0, {32'h0, 32'h04}, 64'h0);
        @(negedge clk);
        chk("ld1_rdata", rdata_o, 32'hA5345678);
        step();
        drv(2'b10, 2'b10, {3'b010, 3'b000}, {32'h21, 32'h0}, {32'hFFFFFFFF, 32'h0});
        @(negedge clk);
        chk("swm_we", mem_we, 4'b0000);
        chk("ldh_rdata", rdata_o, 32'hCAFE0000);
        step();
        drv(2'b01, 2'b01, {3'b000, 3'b011}, {32'h0, 32'h30}, {32'h0, 32'h11223344});
        @(negedge clk);
        chk("swm_err", err_o, 2'b10);
        chk("f3x_we", mem_we, 4'b1111);
        chk("f3x_wdata", mem_wdata, 32'h11223344);
        step();
        drv(2'b01, 2'b00, 6'h0, {32'h0, 32'h30}, 64'h0);
        step();
        drv(2'b10, 2'b00, 6'h0, {32'h20, 32'h0}, 64'h0);
        @(negedge clk);
        chk("rb30_rdata", rdata_o, 32'h11223344);
        step(); idle();
        @(negedge clk);
        chk("rb20_rvalid", rvalid_o, 2'b10);
        chk("rb20_rdata", rdata_o, 32'hA5345678);

        // Reset with a load in flight
        step();
        drv(2'b10, 2'b00, 6'h0, {32'h10, 32'h0}, 64'h0);
        @(negedge clk);
        chk("rip_gnt", gnt_o, 2'b10);
        step();
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rip_rvalid", rvalid_o, 2'b00);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rip_after", rvalid_o, 2'b00);
        step();
        drv(2'b11, 2'b00, 6'h0, {32'h20, 32'h10}, 64'h0);
        @(negedge clk);
        chk("rip_first_gnt", gnt_o, 2'b01);
        step(); idle();
        @(negedge clk);
        chk("rip_first_rdata", rdata_o, 32'hDEADBEEF);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
